// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM with NZCV flag register and cond-field gating.
// Optional macro ILLEGAL_TRAP_EN: op=11 / cond=1111 trap to a sticky HALT state.
module multicycle_controller #(
    parameter int         STATE_W   = 4,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         cond,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic [3:0]         rd,
    input  logic [3:0]         alu_flags,
    output logic               pcwrite,
    output logic               adrsrc,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic [1:0]         resultsrc,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         alucontrol,
    output logic [1:0]         immsrc,
    output logic [1:0]         regsrc,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [STATE_W-1:0] FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] EXER   = STATE_W'(6);
    localparam logic [STATE_W-1:0] EXEI   = STATE_W'(7);
    localparam logic [STATE_W-1:0] ALUWB  = STATE_W'(8);
    localparam logic [STATE_W-1:0] BRANCH = STATE_W'(9);
    localparam logic [STATE_W-1:0] HALT   = STATE_W'(10);

    logic [STATE_W-1:0] state, next_state;
    logic [3:0]         flags;
    logic               condex_q, cond_ok;
    logic [1:0]         alu_dec;
    logic               is_cmp, is_arith, trap;
    logic               pcw_raw, mw_raw, irw_raw, rw_raw;

    logic [3:0] cmd;
    logic       ibit, sbit;
    assign cmd  = funct[4:1];
    assign ibit = funct[5];
    assign sbit = funct[0];

    assign is_cmp = (cmd == 4'b1010);

    always_comb begin
        case (cmd)
            4'b0100: alu_dec = 2'b00;
            4'b0010: alu_dec = 2'b01;
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            4'b1010: alu_dec = 2'b01;
            default: alu_dec = 2'b00;
        endcase
    end

    // C/V are only meaningful for adder results, never for logical ops.
    assign is_arith = (alu_dec == 2'b00) || (alu_dec == 2'b01);

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            4'h0:    cond_ok = z;
            4'h1:    cond_ok = !z;
            4'h2:    cond_ok = c;
            4'h3:    cond_ok = !c;
            4'h4:    cond_ok = n;
            4'h5:    cond_ok = !n;
            4'h6:    cond_ok = v;
            4'h7:    cond_ok = !v;
            4'h8:    cond_ok = c && !z;
            4'h9:    cond_ok = !c || z;
            4'hA:    cond_ok = (n == v);
            4'hB:    cond_ok = (n != v);
            4'hC:    cond_ok = !z && (n == v);
            4'hD:    cond_ok = z || (n != v);
            4'hE:    cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign trap = (op == 2'b11) || (cond == 4'b1111);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                if (trap)              next_state = HALT;
                else if (op == 2'b00)  next_state = ibit ? EXEI : EXER;
                else if (op == 2'b01)  next_state = MEMADR;
                else if (op == 2'b10)  next_state = BRANCH;
                else                   next_state = FETCH;
            end
            MEMADR: next_state = sbit ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            EXER:   next_state = ALUWB;
            EXEI:   next_state = ALUWB;
`ifdef ILLEGAL_TRAP_EN
            HALT:   next_state = HALT;
`endif
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            flags    <= FLAGS_RST;
            condex_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE) condex_q <= cond_ok;
            if ((state == EXER || state == EXEI) && condex_q) begin
                if (is_cmp) begin
                    flags <= alu_flags;
                end else if (sbit) begin
                    flags[3:2] <= alu_flags[3:2];
                    if (is_arith) flags[1:0] <= alu_flags[1:0];
                end
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        illegal <= 1'b0;
        else if (state == DECODE && trap)  illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        pcw_raw    = 1'b0;
        adrsrc     = 1'b0;
        mw_raw     = 1'b0;
        irw_raw    = 1'b0;
        rw_raw     = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 2'b00;
        case (state)
            FETCH: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irw_raw   = 1'b1;
                pcw_raw   = 1'b1;
            end
            DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
            end
            MEMADR: alusrcb = 2'b01;
            MEMRD:  adrsrc  = 1'b1;
            MEMWR: begin
                adrsrc = 1'b1;
                mw_raw = condex_q;
            end
            MEMWB: begin
                resultsrc = 2'b01;
                rw_raw    = condex_q;
                pcw_raw   = condex_q && (rd == 4'hF);
            end
            EXER: alucontrol = alu_dec;
            EXEI: begin
                alusrcb    = 2'b01;
                alucontrol = alu_dec;
            end
            ALUWB: begin
                rw_raw  = condex_q && !is_cmp;
                pcw_raw = condex_q && (rd == 4'hF) && !is_cmp;
            end
            BRANCH: begin
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                pcw_raw   = condex_q;
            end
            default: ;
        endcase
    end

    // Reset forces FETCH, whose decode would otherwise raise pcwrite/irwrite.
    assign pcwrite  = pcw_raw && rst_n;
    assign memwrite = mw_raw  && rst_n;
    assign irwrite  = irw_raw && rst_n;
    assign regwrite = rw_raw  && rst_n;

    assign immsrc    = op;
    assign regsrc    = {op == 2'b01, op == 2'b10};
    assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes expected control words,
// a monitor pops and compares them on each negedge (or an explicit sample event).
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cond, rd, alu_flags;
    logic [1:0] op;
    logic [5:0] funct;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, alusrca, illegal;
    logic [1:0] resultsrc, alusrcb, alucontrol, immsrc, regsrc;
    logic [3:0] dbg_state;

    multicycle_controller #(.STATE_W(4), .FLAGS_RST(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .alucontrol(alucontrol), .immsrc(immsrc), .regsrc(regsrc),
        .illegal(illegal), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] v;
        string       nm;
    } exp_t;

    exp_t  q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    event  samp;

    logic [20:0] act;
    assign act = {dbg_state, pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                  alusrca, alusrcb, alucontrol, immsrc, regsrc, illegal};

    localparam logic [31:0] I_ADD   = 32'hE0821003;
    localparam logic [31:0] I_LDR   = 32'hE5921004;
    localparam logic [31:0] I_STR   = 32'hE5821004;
    localparam logic [31:0] I_SUBS  = 32'hE0521003;
    localparam logic [31:0] I_BEQ   = 32'h0A000002;
    localparam logic [31:0] I_BNE   = 32'h1A000002;
    localparam logic [31:0] I_BCS   = 32'h2A000002;
    localparam logic [31:0] I_BLT   = 32'hBA000002;
    localparam logic [31:0] I_ADDNE = 32'h10821003;
    localparam logic [31:0] I_ORRI  = 32'hE3821005;
    localparam logic [31:0] I_ANDR  = 32'hE0021003;
    localparam logic [31:0] I_CMP15 = 32'hE152F003;
    localparam logic [31:0] I_OP11  = 32'hEC000000;
    localparam logic [31:0] I_NV    = 32'hF0821003;

    // Hand-tabulated select values per state; enables and alucontrol come from the caller.
    function automatic logic [20:0] mk(input logic [3:0] st, input logic pcw, input logic mw,
                                       input logic rw, input logic [1:0] ac,
                                       input logic [31:0] ins, input logic ill);
        logic       adr, asa, irw;
        logic [1:0] rs, asb, o;
        adr = 1'b0; asa = 1'b0; rs = 2'b00; asb = 2'b00;
        case (st)
            4'd0, 4'd1: begin asa = 1'b1; asb = 2'b10; rs = 2'b10; end
            4'd2:       asb = 2'b01;
            4'd3, 4'd5: adr = 1'b1;
            4'd4:       rs = 2'b01;
            4'd7:       asb = 2'b01;
            4'd9:       begin asb = 2'b01; rs = 2'b10; end
            default: ;
        endcase
        irw = (st == 4'd0) && pcw;
        o   = ins[27:26];
        return {st, pcw, adr, mw, irw, rw, rs, asa, asb, ac, o, o == 2'b01, o == 2'b10, ill};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [3:0] af);
        cond = ins[31:28]; op = ins[27:26]; funct = ins[25:20]; rd = ins[15:12];
        alu_flags = af;
    endtask

    task automatic push(input string nm, input logic [20:0] v);
        exp_t e;
        e.v = v; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic cyc(input string nm, input logic [31:0] ins, input logic [3:0] af,
                       input logic [3:0] st, input logic pcw, input logic mw, input logic rw,
                       input logic [1:0] ac, input logic ill);
        drive(ins, af);
        push(nm, mk(st, pcw, mw, rw, ac, ins, ill));
        @(posedge clk); #1;
    endtask

    task automatic fd(input string nm, input logic [31:0] ins);
        cyc({nm, "/F"}, ins, 4'h0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc({nm, "/D"}, ins, 4'h0, 4'd1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic dp(input string nm, input logic [31:0] ins, input logic [3:0] af,
                      input logic [3:0] st_ex, input logic [1:0] ac, input logic rw,
                      input logic pw);
        fd(nm, ins);
        cyc({nm, "/EX"}, ins, af, st_ex, 1'b0, 1'b0, 1'b0, ac, 1'b0);
        cyc({nm, "/WB"}, ins, 4'h0, 4'd8, pw, 1'b0, rw, 2'b00, 1'b0);
    endtask

    task automatic br(input string nm, input logic [31:0] ins, input logic pw);
        fd(nm, ins);
        cyc({nm, "/BR"}, ins, 4'h0, 4'd9, pw, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic reset_pulse(input logic [31:0] ins);
        rst_n = 1'b0;
        cyc("rst_pulse", ins, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or samp);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %b want %b", e.nm, act, e.v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(I_ADD, 4'h0);
        @(posedge clk); #1;
        cyc("rst0", I_ADD, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc("rst1", I_ADD, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b1;

        dp("add",  I_ADD,  4'h0, 4'd6, 2'b00, 1'b1, 1'b0);
        fd("ldr",  I_LDR);
        cyc("ldr/ADR", I_LDR, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc("ldr/RD",  I_LDR, 4'h0, 4'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc("ldr/WB",  I_LDR, 4'h0, 4'd4, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        fd("str",  I_STR);
        cyc("str/ADR", I_STR, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc("str/WR",  I_STR, 4'h0, 4'd5, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);

        // SUBS with Z set from the ALU -> flags 0100
        dp("subs", I_SUBS, 4'b0100, 4'd6, 2'b01, 1'b1, 1'b0);
        br("beq_t", I_BEQ, 1'b1);
        br("bne_n", I_BNE, 1'b0);
        dp("addne", I_ADDNE, 4'h0, 4'd6, 2'b00, 1'b0, 1'b0);
        dp("orri",  I_ORRI, 4'b1011, 4'd7, 2'b11, 1'b1, 1'b0);
        dp("andr",  I_ANDR, 4'b1011, 4'd6, 2'b10, 1'b1, 1'b0);
        br("beq_t2", I_BEQ, 1'b1);

        // CMP to R15: no writeback, all four flags from ALU (0011)
        dp("cmp15", I_CMP15, 4'b0011, 4'd6, 2'b01, 1'b0, 1'b0);
        br("bcs_t", I_BCS, 1'b1);
        br("beq_n", I_BEQ, 1'b0);
        br("blt_t", I_BLT, 1'b1);

        // Asynchronous reset in the middle of MEMWR
        fd("str2", I_STR);
        cyc("str2/ADR", I_STR, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        drive(I_STR, 4'h0);
        push("str2/WR", mk(4'd5, 1'b0, 1'b1, 1'b0, 2'b00, I_STR, 1'b0));
        @(negedge clk); #2;
        rst_n = 1'b0;
        push("async_rst", mk(4'd0, 1'b0, 1'b0, 1'b0, 2'b00, I_STR, 1'b0));
        #1 -> samp;
        @(posedge clk); #1;
        cyc("rst_hold", I_STR, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b1;
        br("bcs_after_rst", I_BCS, 1'b0);

`ifdef ILLEGAL_TRAP_EN
        fd("nv", I_NV);
        cyc("nv/HALT", I_NV, 4'h0, 4'd10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        reset_pulse(I_OP11);
        fd("op11", I_OP11);
        for (int i = 0; i < 20; i++)
            cyc("op11/HALT", I_OP11, 4'h0, 4'd10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
`else
        dp("nv", I_NV, 4'b1111, 4'd6, 2'b00, 1'b0, 1'b0);
        br("bcs_after_nv", I_BCS, 1'b0);
        reset_pulse(I_OP11);
        fd("op11", I_OP11);
        cyc("op11/NEXT", I_OP11, 4'h0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
`endif

        @(negedge clk); #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM plus condition-check unit that converts the single-cycle ARM-subset datapath into a multicycle one.
- Instruction and data memories are shared through one address mux.
- Drives every datapath select and write enable per state.
- Holds the NZCV flag register and gates architectural writes by the instruction's cond field.
- Sits beside the register file/ALU and replaces control_decoder in the multicycle MCU top.

Parameters:
- STATE_W, 4, width of the state register and the dbg_state port.
- FLAGS_RST, 4'b0000, NZCV value loaded at reset.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cond  in  4  instr[31:28], taken from the instruction register.
- op  in  2  instr[27:26].
- funct  in  6  instr[25:20]: I = [5], cmd = [4:1], S/L = [0].
- rd  in  4  instr[15:12].
- alu_flags  in  4  NZCV from ALU32bit, combinational, current cycle.
- pcwrite  out  1  PC register enable.
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  shared memory write enable.
- irwrite  out  1  instruction register enable.
- regwrite  out  1  register file WE3.
- resultsrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alusrca  out  1  ALU A select: 0 = RD1 reg, 1 = PC.
- alusrcb  out  2  ALU B select: 00 = RD2 reg, 01 = ExtImm, 10 = constant 4.
- alucontrol  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- immsrc  out  2  equals op.
- regsrc  out  2  [0] = (op==10), [1] = (op==01).
- illegal  out  1  sticky illegal-instruction flag; see Optional Feature.
- dbg_state  out  STATE_W  current state encoding.

Behaviour:
- Reset (rst_n low, async): state=FETCH, flags=FLAGS_RST, condex_q=0, illegal=0. Control outputs follow FETCH decode immediately.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXER=6, EXEI=7, ALUWB=8, BRANCH=9, HALT=10. Unused encodings go to FETCH on the next edge.
- Transitions:
  - FETCH->DECODE.
  - DECODE: op=00 with I=0 -> EXER; op=00 with I=1 -> EXEI; op=01 -> MEMADR; op=10 -> BRANCH; op=11 -> FETCH (HALT under the macro).
  - MEMADR: L=1 -> MEMRD, L=0 -> MEMWR.
  - MEMRD->MEMWB->FETCH. MEMWR->FETCH.
  - EXER/EXEI->ALUWB->FETCH. BRANCH->FETCH.
- Per-state outputs (unlisted signals are 0):
  - FETCH: adrsrc=0, alusrca=1, alusrcb=10, ADD, resultsrc=10, irwrite=1, pcwrite=1.
  - DECODE: alusrca=1, alusrcb=10, ADD, resultsrc=10 (R15 = PC+8).
  - MEMADR: alusrca=0, alusrcb=01, ADD.
  - MEMRD: adrsrc=1, resultsrc=00.
  - MEMWR: adrsrc=1, memwrite=condex_q.
  - MEMWB: resultsrc=01, regwrite=condex_q; pcwrite=condex_q & (rd==15).
  - EXER: alusrcb=00, alucontrol decoded from cmd. EXEI: same with alusrcb=01.
  - ALUWB: resultsrc=00; regwrite=condex_q & !CMP; pcwrite=condex_q & (rd==15) & !CMP.
  - BRANCH: alusrca=0, alusrcb=01, ADD, resultsrc=10, pcwrite=condex_q.
- cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no writeback). Other cmd values are treated as ADD.
- condex_q captured at the DECODE->next edge from the current flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; cond 1111 gives 0.
- Flag update at the end of EXER/EXEI, only when condex_q=1:
  - S=1: N,Z <= alu_flags[3:2].
  - C,V <= alu_flags[1:0] only when S=1 and the op is ADD/SUB/CMP.
  - CMP always writes all four flags regardless of S.
- regsrc and immsrc are pure decode of the inputs.
- A condex_q=0 instruction still walks its full state path with writes suppressed; the PC still advances from FETCH.
- rst_n asserted in any state aborts the instruction; no write enable may be high during reset.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: op=11 or cond=1111 in DECODE -> HALT, illegal<=1. HALT holds all enables 0 until rst_n.
- Undefined: op=11 returns to FETCH as a NOP, cond=1111 executes as never-true, illegal ties to 0, HALT is unreachable.

Test Plan:
- Reset low mid-MEMWR -> state=0, memwrite=0 asynchronously, flags=0000; after release, first posedge state=1.
- ADD R1,R2,R3 (E0821003) -> states 0,1,6,8,0; regwrite=1 only in state 8; alucontrol=00 in state 6.
- LDR (E5921004) -> states 0,1,2,3,4; adrsrc=1 in state 3; resultsrc=01 with regwrite=1 in state 4.
- SUBS with alu_flags=0100, then BEQ (0A000002) -> flags=0100; BRANCH pcwrite=1. Repeat with BNE -> pcwrite=0 in BRANCH.
- CMP with rd=15 -> ALUWB regwrite=0, pcwrite=0, flags updated.
- With ILLEGAL_TRAP_EN, op=11 -> state=10, illegal=1, held over 20 cycles. Without it, returns to state 0 and illegal=0.
